// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath: width, ALU opcodes and the flag bundle.
package cpu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OP_W  = 5;

    localparam logic [OP_W-1:0] OP_AND   = 5'h00;
    localparam logic [OP_W-1:0] OP_EOR   = 5'h01;
    localparam logic [OP_W-1:0] OP_SUB   = 5'h02;
    localparam logic [OP_W-1:0] OP_RSB   = 5'h03;
    localparam logic [OP_W-1:0] OP_ADD   = 5'h04;
    localparam logic [OP_W-1:0] OP_ADC   = 5'h05;
    localparam logic [OP_W-1:0] OP_SBC   = 5'h06;
    localparam logic [OP_W-1:0] OP_RSC   = 5'h07;
    localparam logic [OP_W-1:0] OP_TST   = 5'h08;
    localparam logic [OP_W-1:0] OP_TEQ   = 5'h09;
    localparam logic [OP_W-1:0] OP_CMP   = 5'h0A;
    localparam logic [OP_W-1:0] OP_CMN   = 5'h0B;
    localparam logic [OP_W-1:0] OP_ORR   = 5'h0C;
    localparam logic [OP_W-1:0] OP_MOV   = 5'h0D;
    localparam logic [OP_W-1:0] OP_BIC   = 5'h0E;
    localparam logic [OP_W-1:0] OP_MVN   = 5'h0F;
    localparam logic [OP_W-1:0] OP_PASSA = 5'h10;
    localparam logic [OP_W-1:0] OP_INC4  = 5'h11;
    localparam logic [OP_W-1:0] OP_ADD4  = 5'h12;
    localparam logic [OP_W-1:0] OP_DEC4  = 5'h13;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_ir_mar_datapath_if.sv
// Control/data bus between the control unit and the ALU/IR/MAR datapath slice.
interface alu_ir_mar_datapath_if;
    import cpu_pkg::*;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OP_W-1:0]  alu_op;
    logic             carry_in;
    logic             ir_ld;
    logic [WIDTH-1:0] ir_in;
    logic             mar_ld;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic [WIDTH-1:0] ir_out;
    logic [WIDTH-1:0] mar_out;

    modport master (
        output alu_a, alu_b, alu_op, carry_in, ir_ld, ir_in, mar_ld,
        input  result, flag_n, flag_z, flag_c, flag_v, ir_out, mar_out
    );

    modport slave (
        input  alu_a, alu_b, alu_op, carry_in, ir_ld, ir_in, mar_ld,
        output result, flag_n, flag_z, flag_c, flag_v, ir_out, mar_out
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU with NZCV flags; all adds/subtracts share one 33-bit adder.
module alu_core
    import cpu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    localparam int unsigned SW  = WIDTH + 1;
    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic [SW-1:0]    add_k;
    logic [SW-1:0]    sum;
    logic [WIDTH-1:0] logic_res;
    logic             is_arith;
    logic             is_valid;

    // Operand selection: subtraction X-Y is presented as X + ~Y + 1.
    always_comb begin
        add_x     = '0;
        add_y     = '0;
        add_k     = '0;
        logic_res = '0;
        is_arith  = 1'b0;
        is_valid  = 1'b1;
        case (op)
            OP_AND, OP_TST: logic_res = a & b;
            OP_EOR, OP_TEQ: logic_res = a ^ b;
            OP_ORR:         logic_res = a | b;
            OP_MOV:         logic_res = b;
            OP_BIC:         logic_res = a & ~b;
            OP_MVN:         logic_res = ~b;
            OP_PASSA:       logic_res = a;
            OP_SUB, OP_CMP: begin is_arith = 1'b1; add_x = a; add_y = ~b; add_k = SW'(1); end
            OP_RSB:         begin is_arith = 1'b1; add_x = b; add_y = ~a; add_k = SW'(1); end
            OP_ADD, OP_CMN: begin is_arith = 1'b1; add_x = a; add_y = b; end
            OP_ADC:         begin is_arith = 1'b1; add_x = a; add_y = b;  add_k = SW'(cin); end
            OP_SBC:         begin is_arith = 1'b1; add_x = a; add_y = ~b; add_k = SW'(cin); end
            OP_RSC:         begin is_arith = 1'b1; add_x = b; add_y = ~a; add_k = SW'(cin); end
            OP_INC4:        begin is_arith = 1'b1; add_x = a; add_y = WIDTH'(4); end
            OP_ADD4:        begin is_arith = 1'b1; add_x = a; add_y = b;  add_k = SW'(4); end
            OP_DEC4:        begin is_arith = 1'b1; add_x = a; add_y = ~WIDTH'(4); add_k = SW'(1); end
            default:        is_valid = 1'b0;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + add_k;

    // Result and flag formation; reserved opcodes give zero with only Z set.
    always_comb begin
        result  = '0;
        flags.c = 1'b0;
        flags.v = 1'b0;
        if (is_arith) begin
            result  = sum[MSB:0];
            flags.c = sum[WIDTH];
            flags.v = (add_x[MSB] == add_y[MSB]) && (sum[MSB] != add_x[MSB]);
        end else if (is_valid) begin
            result  = logic_res;
            flags.c = cin;
        end
        flags.n = result[MSB];
        flags.z = (result == '0);
    end

endmodule

// File: rtl/alu_ir_mar_datapath.sv
// Datapath slice: combinational ALU, Instruction Register and Memory Address Register.
module alu_ir_mar_datapath
    import cpu_pkg::*;
(
    input  logic                 CLK,
    input  logic                 CLR,
    alu_ir_mar_datapath_if.slave bus
);

    logic [WIDTH-1:0] alu_result;
    flags_t           alu_flags;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] mar_q;

    alu_core u_alu (
        .a      (bus.alu_a),
        .b      (bus.alu_b),
        .op     (bus.alu_op),
        .cin    (bus.carry_in),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // IR captures the memory read word.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            ir_q <= '0;
        end else if (bus.ir_ld) begin
            ir_q <= bus.ir_in;
        end
    end

    // MAR captures this cycle's ALU result as the next memory address.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            mar_q <= '0;
        end else if (bus.mar_ld) begin
            mar_q <= alu_result;
        end
    end

    assign bus.result  = alu_result;
    assign bus.flag_n  = alu_flags.n;
    assign bus.flag_z  = alu_flags.z;
    assign bus.flag_c  = alu_flags.c;
    assign bus.flag_v  = alu_flags.v;
    assign bus.ir_out  = ir_q;
    assign bus.mar_out = mar_q;

endmodule

// File: tb/tb_alu_ir_mar_datapath.sv
// Directed table-driven bench for the ALU/IR/MAR datapath slice.
module tb_alu_ir_mar_datapath;
    import cpu_pkg::*;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_res;
        logic [3:0]  exp_nzcv;
    } vec_t;

    localparam int NV = 24;

    logic clk;
    logic clr;
    int   total;
    int   bad;
    vec_t vecs [NV];

    alu_ir_mar_datapath_if bus ();

    alu_ir_mar_datapath dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // op, a, b, cin, result, nzcv
        vecs[0]  = '{5'h04, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1001};
        vecs[1]  = '{5'h0A, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b0110};
        vecs[2]  = '{5'h02, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 4'b1000};
        vecs[3]  = '{5'h05, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0110};
        vecs[4]  = '{5'h06, 32'h0000000A, 32'h00000003, 1'b0, 32'h00000006, 4'b0010};
        vecs[5]  = '{5'h0E, 32'h000000FF, 32'h0000000F, 1'b1, 32'h000000F0, 4'b0010};
        vecs[6]  = '{5'h0F, 32'h12345678, 32'h00000000, 1'b0, 32'hFFFFFFFF, 4'b1000};
        vecs[7]  = '{5'h0F, 32'h12345678, 32'h00000000, 1'b1, 32'hFFFFFFFF, 4'b1010};
        vecs[8]  = '{5'h11, 32'h00000100, 32'hDEADBEEF, 1'b1, 32'h00000104, 4'b0000};
        vecs[9]  = '{5'h15, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 4'b0100};
        vecs[10] = '{5'h03, 32'h00000001, 32'h00000000, 1'b0, 32'hFFFFFFFF, 4'b1000};
        vecs[11] = '{5'h07, 32'h00000000, 32'h00000005, 1'b1, 32'h00000005, 4'b0010};
        vecs[12] = '{5'h13, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFC, 4'b1000};
        vecs[13] = '{5'h13, 32'h80000000, 32'h00000000, 1'b0, 32'h7FFFFFFC, 4'b0011};
        vecs[14] = '{5'h12, 32'h7FFFFFFC, 32'h00000000, 1'b0, 32'h80000000, 4'b1001};
        vecs[15] = '{5'h12, 32'h00000010, 32'h00000020, 1'b0, 32'h00000034, 4'b0000};
        vecs[16] = '{5'h00, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 4'b1000};
        vecs[17] = '{5'h09, 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 4'b0110};
        vecs[18] = '{5'h0C, 32'h0000000F, 32'h000000F0, 1'b0, 32'h000000FF, 4'b0000};
        vecs[19] = '{5'h0D, 32'h00000001, 32'h80000000, 1'b0, 32'h80000000, 4'b1000};
        vecs[20] = '{5'h10, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4'b0100};
        vecs[21] = '{5'h0B, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b0110};
        vecs[22] = '{5'h04, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b0110};
        vecs[23] = '{5'h1F, 32'h00000001, 32'h00000002, 1'b0, 32'h00000000, 4'b0100};

        clr          = 1'b1;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_op   = '0;
        bus.carry_in = 1'b0;
        bus.ir_ld    = 1'b0;
        bus.ir_in    = '0;
        bus.mar_ld   = 1'b0;
        tick();
        check("reset_ir", 64'(bus.ir_out), 64'h0);
        check("reset_mar", 64'(bus.mar_out), 64'h0);
        clr = 1'b0;

        // Combinational ALU vectors.
        for (int i = 0; i < NV; i++) begin
            bus.alu_op   = vecs[i].op;
            bus.alu_a    = vecs[i].a;
            bus.alu_b    = vecs[i].b;
            bus.carry_in = vecs[i].cin;
            #1;
            check($sformatf("vec%0d_op%02h_res", i, vecs[i].op), 64'(bus.result), 64'(vecs[i].exp_res));
            check($sformatf("vec%0d_op%02h_nzcv", i, vecs[i].op),
                  64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'(vecs[i].exp_nzcv));
        end

        // Both loads in one cycle: IR from memory data, MAR from the ADD overflow result.
        @(negedge clk);
        bus.alu_op   = OP_ADD;
        bus.alu_a    = 32'h7FFFFFFF;
        bus.alu_b    = 32'h00000001;
        bus.carry_in = 1'b0;
        bus.ir_in    = 32'hE3A01005;
        bus.ir_ld    = 1'b1;
        bus.mar_ld   = 1'b1;
        tick();
        check("load_ir", 64'(bus.ir_out), 64'hE3A01005);
        check("load_mar", 64'(bus.mar_out), 64'h80000000);

        // Reset takes priority over pending loads.
        @(negedge clk);
        clr       = 1'b1;
        bus.ir_in = 32'hCAFEF00D;
        bus.alu_a = 32'h00001000;
        bus.alu_b = 32'h00000004;
        tick();
        check("clr_prio_ir", 64'(bus.ir_out), 64'h0);
        check("clr_prio_mar", 64'(bus.mar_out), 64'h0);

        // IR load then hold; MAR loads INC4 result then holds.
        @(negedge clk);
        clr        = 1'b0;
        bus.ir_in  = 32'h12345678;
        bus.ir_ld  = 1'b1;
        bus.alu_op = OP_INC4;
        bus.alu_a  = 32'h00000100;
        bus.mar_ld = 1'b1;
        tick();
        check("ir_load", 64'(bus.ir_out), 64'h12345678);
        check("mar_load_inc4", 64'(bus.mar_out), 64'h00000104);

        @(negedge clk);
        bus.ir_ld  = 1'b0;
        bus.mar_ld = 1'b0;
        bus.ir_in  = 32'hDEADBEEF;
        bus.alu_a  = 32'h00005000;
        tick();
        tick();
        check("ir_hold", 64'(bus.ir_out), 64'h12345678);
        check("mar_hold", 64'(bus.mar_out), 64'h00000104);

        // Independent loads: only MAR this time.
        @(negedge clk);
        bus.mar_ld = 1'b1;
        bus.alu_op = OP_SUB;
        bus.alu_a  = 32'h00000003;
        bus.alu_b  = 32'h00000005;
        tick();
        check("mar_only_mar", 64'(bus.mar_out), 64'hFFFFFFFE);
        check("mar_only_ir", 64'(bus.ir_out), 64'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
